// File: rtl/mult_iter.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per cycle,
// with valid/ready on both sides and an optional two's-complement mode.
module mult_iter #(
    parameter int DATA_WIDTH     = 12,
    parameter int BITS_PER_CYCLE = 2,
    parameter int SIGNED_MODE    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      abort_i,
    output logic [2*DATA_WIDTH-1:0]   p_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

    localparam int W  = DATA_WIDTH;
    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = W / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_width_check
        $error("mult_iter: BITS_PER_CYCLE must divide DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [2*W-1:0]  a_sh;
    logic [W-1:0]    b_sh;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic            neg;

    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            sign_in;
    logic [2*W-1:0]  partial;
    logic [2*W-1:0]  sum;

    // The magnitude of the most negative value still fits in W unsigned bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        a_mag   = a_i;
        b_mag   = b_i;
        sign_in = 1'b0;
        if (SIGNED_MODE != 0) begin
            if (a_i[W-1]) a_mag = -a_i;
            if (b_i[W-1]) b_mag = -b_i;
            sign_in = a_i[W-1] ^ b_i[W-1];
        end
        partial = a_sh * {{(2*W-K){1'b0}}, b_sh[K-1:0]};
        sum     = acc + partial;
    end

    // Multiplicand is pre-shifted and multiplier post-shifted so the digit is always the low K bits.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            p_o     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_sh    <= {{W{1'b0}}, a_mag};
                        b_sh    <= b_mag;
                        neg     <= sign_in;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= CALC;
                        ready_o <= 1'b0;
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        acc  <= sum;
                        cnt  <= cnt + 1'b1;
                        a_sh <= a_sh << K;
                        b_sh <= b_sh >> K;
                        if (cnt == LAST) begin
                            p_o     <= neg ? -sum : sum;
                            state   <= DONE;
                            valid_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort_i || ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// Directed bench for mult_iter: six instances cover unsigned/signed K=2 and the K sweep.
module tb_mult_iter;

    localparam int NI = 6;
    localparam int KS [0:NI-1] = '{2, 2, 1, 3, 4, 12};
    localparam int SM [0:NI-1] = '{0, 1, 0, 0, 0, 0};

    logic        clk;
    logic        rst;
    logic [11:0] a    [NI];
    logic [11:0] b    [NI];
    logic        vin  [NI];
    logic        rdy  [NI];
    logic        abt  [NI];
    logic [23:0] p    [NI];
    logic        vout [NI];
    logic        rin  [NI];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mult_iter #(
            .DATA_WIDTH    (12),
            .BITS_PER_CYCLE(KS[g]),
            .SIGNED_MODE   (SM[g])
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .a_i    (a[g]),
            .b_i    (b[g]),
            .valid_i(vin[g]),
            .ready_o(rdy[g]),
            .abort_i(abt[g]),
            .p_o    (p[g]),
            .valid_o(vout[g]),
            .ready_i(rin[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept(input int i, input logic [11:0] av, input logic [11:0] bv, input string name);
        @(posedge clk); #1;
        checks++;
        if (rdy[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_o before accept: got %b want 1", name, rdy[i]);
        end
        a[i] = av; b[i] = bv; vin[i] = 1'b1;
        @(posedge clk); #1;
        vin[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, output int cyc);
        cyc = 0;
        while (vout[i] !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_op(input int i, input logic [11:0] av, input logic [11:0] bv,
                         input logic [23:0] exp, input int lat, input string name);
        int cyc;
        accept(i, av, bv, name);
        wait_valid(i, cyc);
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        checks++;
        if (p[i] !== exp) begin
            errors++;
            $display("FAIL %s product: got %h want %h", name, p[i], exp);
        end
        if (rin[i]) begin
            @(posedge clk); #1;
            checks++;
            if (vout[i] !== 1'b0 || rdy[i] !== 1'b1) begin
                errors++;
                $display("FAIL %s handshake: got valid_o=%b ready_o=%b want 0/1", name, vout[i], rdy[i]);
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdy[i] !== 1'b1 || vout[i] !== 1'b0 || p[i] !== 24'h0) begin
                errors++;
                $display("FAIL reset_%0d: got ready=%b valid=%b p=%h want 1/0/000000", i, rdy[i], vout[i], p[i]);
            end
        end
    endtask

    task automatic test_unsigned;
        do_op(0, 12'd4095, 12'd4095, 24'hFFE001, 6, "unsigned_max");
        do_op(0, 12'd1234, 12'd567, 24'd699678, 6, "unsigned_mix");
    endtask

    task automatic test_signed;
        do_op(1, 12'h800, 12'h800, 24'h400000, 6, "signed_minmin");
        do_op(1, 12'hFFF, 12'd5, 24'hFFFFFB, 6, "signed_m1x5");
        do_op(1, 12'd0, 12'hFF9, 24'h000000, 6, "signed_0xm7");
        do_op(1, 12'd3, 12'hFFC, 24'hFFFFF4, 6, "signed_3xm4");
    endtask

    task automatic test_backpressure;
        int cyc;
        int bad;
        rin[0] = 1'b0;
        accept(0, 12'd100, 12'd200, "bp");
        wait_valid(0, cyc);
        checks++;
        if (cyc != 6 || p[0] !== 24'd20000) begin
            errors++;
            $display("FAIL bp_result: got lat=%0d p=%0d want 6/20000", cyc, p[0]);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            a[0] = 12'd7; b[0] = 12'd9; vin[0] = k[0];
            @(posedge clk); #1;
            if (p[0] !== 24'd20000 || vout[0] !== 1'b1 || rdy[0] !== 1'b0) bad++;
        end
        vin[0] = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        rin[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (vout[0] !== 1'b0 || rdy[0] !== 1'b1 || p[0] !== 24'd20000) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b p=%0d want 0/1/20000", vout[0], rdy[0], p[0]);
        end
    endtask

    task automatic test_reset_mid;
        accept(0, 12'd4095, 12'd4095, "rst_mid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || vout[0] !== 1'b0 || p[0] !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_state: got ready=%b valid=%b p=%h want 1/0/000000", rdy[0], vout[0], p[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(0, 12'd3, 12'd7, 24'd21, 6, "after_rst");
    endtask

    task automatic test_abort;
        int seen;
        accept(0, 12'd5, 12'd9, "abort");
        @(posedge clk); #1;
        abt[0] = 1'b1;
        @(posedge clk); #1;
        abt[0] = 1'b0;
        checks++;
        if (rdy[0] !== 1'b1 || vout[0] !== 1'b0 || p[0] !== 24'd21) begin
            errors++;
            $display("FAIL abort_state: got ready=%b valid=%b p=%0d want 1/0/21", rdy[0], vout[0], p[0]);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (vout[0] !== 1'b0 || p[0] !== 24'd21) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d bad cycles want 0", seen);
        end
    endtask

    task automatic test_sweep;
        do_op(2, 12'd2730, 12'd1365, 24'd3726450, 12, "k1");
        do_op(3, 12'd1234, 12'd567,  24'd699678,  4,  "k3");
        do_op(4, 12'd4095, 12'd4095, 24'hFFE001,  3,  "k4");
        do_op(5, 12'd3000, 12'd2,    24'd6000,    1,  "k12");
        do_op(5, 12'd4095, 12'd4095, 24'hFFE001,  1,  "k12_max");
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            a[i] = '0; b[i] = '0; vin[i] = 1'b0; abt[i] = 1'b0; rin[i] = 1'b1;
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        test_reset;
        test_unsigned;
        test_signed;
        test_backpressure;
        test_reset_mid;
        test_abort;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
